xdma_axil_regfile: RTL

- AXI4-Lite responder (slave) for the XDMA user-side AXI-Lite master port (xdma_0 m_axil_*). Terminates host BAR MMIO accesses.
- Holds a small control/status register file: ID, status, doorbell and read/write config registers.
- Doorbell writes produce a one-cycle notification pulse toward the virtio queue logic.
- One outstanding write and one outstanding read, handled on independent channels.

---
 rtl/xdma_axil_regfile_pkg.sv | 9 +
 rtl/xdma_axil_regfile_if.sv | 30 +++
 rtl/xdma_axil_regfile_strb_merge.sv | 11 +
 rtl/xdma_axil_regfile.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/xdma_axil_regfile_pkg.sv
// xdma_axil_pkg: shared response codes, register indices and FSM states for the XDMA AXI-Lite register file.
package xdma_axil_pkg;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_t;
  localparam int REG_ID = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_DOORBELL = 2;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/xdma_axil_regfile_if.sv
// xdma_axil_regfile_if: AXI4-Lite bus bundle with master/slave views.
interface xdma_axil_regfile_if #(parameter int ADDR_W = 32) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid;
  logic wready;
  logic bvalid;
  logic [1:0] bresp;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/xdma_axil_regfile_strb_merge.sv
// xdma_axil_strb_merge: byte-enable merge of new data over old data.
module xdma_axil_strb_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
  end
endmodule

// File: rtl/xdma_axil_regfile.sv
// xdma_axil_regfile: AXI4-Lite control/status register file behind the XDMA user BAR.
// Optional doorbell interrupt request enabled by XDMA_AXIL_DOORBELL_IRQ_EN.
module xdma_axil_regfile
  import xdma_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h5649_5254
) (
  input  logic axi_aclk,
  input  logic axi_areset,
  xdma_axil_regfile_if.slave s_axil,
  input  logic [31:0] status_i,
  output logic [NUM_REGS*32-1:0] cfg_o,
  output logic doorbell_valid_o,
  output logic [31:0] doorbell_data_o
`ifdef XDMA_AXIL_DOORBELL_IRQ_EN
  ,
  output logic usr_irq_req_o,
  input  logic usr_irq_ack_i
`endif
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS * 4);
  localparam logic [IW-1:0] IDX_ID = IW'(REG_ID);
  localparam logic [IW-1:0] IDX_STATUS = IW'(REG_STATUS);
  localparam logic [IW-1:0] IDX_DB = IW'(REG_DOORBELL);
  w_state_t w_state;
  r_state_t r_state;
  logic aw_got, w_got;
  logic [ADDR_W-1:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0] w_strb;
  logic [31:0] regs [NUM_REGS];
  logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok, db_hit;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0] c_data, old_data, merged, rd_val;
  logic [3:0] c_strb;
  logic [IW-1:0] w_idx, r_idx;
  logic unused;
  assign unused = ^{s_axil.awprot, s_axil.arprot};
  assign aw_hs = s_axil.awvalid && s_axil.awready;
  assign w_hs = s_axil.wvalid && s_axil.wready;
  assign ar_hs = s_axil.arvalid && s_axil.arready;
  // A beat handshaking this edge counts as captured, so AW and W together commit at once.
  assign commit = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign c_addr = aw_hs ? s_axil.awaddr : aw_addr;
  assign c_data = w_hs ? s_axil.wdata : w_data;
  assign c_strb = w_hs ? s_axil.wstrb : w_strb;
  assign w_ok = c_addr < LIMIT;
  assign w_idx = c_addr[IW+1:2];
  assign db_hit = commit && w_ok && (w_idx == IDX_DB);
  assign old_data = (w_idx == IDX_DB) ? 32'h0 : regs[w_idx];
  assign r_ok = s_axil.araddr < LIMIT;
  assign r_idx = s_axil.araddr[IW+1:2];
  xdma_axil_strb_merge u_merge (
    .old_data(old_data),
    .new_data(c_data),
    .strb(c_strb),
    .merged(merged)
  );
  always_comb begin
    rd_val = !r_ok ? 32'h0 :
             (r_idx == IDX_ID) ? ID_VALUE :
             (r_idx == IDX_STATUS) ? status_i :
             (r_idx == IDX_DB) ? 32'h0 : regs[r_idx];
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_o[32*g +: 32] = regs[g];
  end
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      w_state <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axil.awready <= 1'b0;
      s_axil.wready <= 1'b0;
      s_axil.bvalid <= 1'b0;
      s_axil.bresp <= RESP_OKAY;
      doorbell_valid_o <= 1'b0;
      doorbell_data_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      doorbell_valid_o <= 1'b0;
      if (w_state == W_IDLE) begin
        if (aw_hs) begin
          aw_got <= 1'b1;
          aw_addr <= s_axil.awaddr;
        end
        if (w_hs) begin
          w_got <= 1'b1;
          w_data <= s_axil.wdata;
          w_strb <= s_axil.wstrb;
        end
        if (commit) begin
          s_axil.awready <= 1'b0;
          s_axil.wready <= 1'b0;
          s_axil.bvalid <= 1'b1;
          s_axil.bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
          w_state <= W_RESP;
          if (db_hit) begin
            doorbell_valid_o <= 1'b1;
            doorbell_data_o <= merged;
          end
          if (w_ok && w_idx > IDX_DB) regs[w_idx] <= merged;
        end else begin
          s_axil.awready <= !(aw_got || aw_hs);
          s_axil.wready <= !(w_got || w_hs);
        end
      end else if (s_axil.bready) begin
        s_axil.bvalid <= 1'b0;
        aw_got <= 1'b0;
        w_got <= 1'b0;
        s_axil.awready <= 1'b1;
        s_axil.wready <= 1'b1;
        w_state <= W_IDLE;
      end
    end
  end
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state <= R_IDLE;
      s_axil.arready <= 1'b0;
      s_axil.rvalid <= 1'b0;
      s_axil.rdata <= '0;
      s_axil.rresp <= RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        s_axil.rdata <= rd_val;
        s_axil.rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
        s_axil.rvalid <= 1'b1;
        s_axil.arready <= 1'b0;
        r_state <= R_DATA;
      end else begin
        s_axil.arready <= 1'b1;
      end
    end else if (s_axil.rready) begin
      s_axil.rvalid <= 1'b0;
      s_axil.arready <= 1'b1;
      r_state <= R_IDLE;
    end
  end
`ifdef XDMA_AXIL_DOORBELL_IRQ_EN
  // New doorbells while a request is pending merge into it; set wins over a coincident ack.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) usr_irq_req_o <= 1'b0;
    else if (db_hit) usr_irq_req_o <= 1'b1;
    else if (usr_irq_ack_i) usr_irq_req_o <= 1'b0;
  end
`endif
endmodule
